// File: rtl/cascade_counter_chain.sv
// ============================================================================
// Module   : cascade_counter_chain
// Purpose  : Chain of STAGES modulo counters with ripple carry. Stage 0 is
//            the least significant stage. The default MAX produces HUB-75 scan
//            coordinates: column 0..63, row address 0..15, BCM bit-plane 0..7.
//            Each stage has its own modulus. The chain supports synchronous
//            clear, parallel load with range checking, and per-stage wrap
//            pulses.
// Options  : Define CASCADE_CHAIN_DOWN_EN to add the `down` input and the
//            `stage_zero` output. With down=1 the chain decrements, and the
//            carry outputs act as borrows.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cascade_counter_chain #(
  parameter int unsigned                 STAGES = 3,
  parameter int unsigned                 WIDTH  = 8,
  parameter logic [STAGES*WIDTH-1:0]     MAX    = 24'h070F3F
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       load,
  input  logic [STAGES*WIDTH-1:0]    load_value,
`ifdef CASCADE_CHAIN_DOWN_EN
  input  logic                       down,
  output logic [STAGES-1:0]          stage_zero,
`endif
  output logic [STAGES*WIDTH-1:0]    count,
  output logic [STAGES-1:0]          stage_max,
  output logic [STAGES-1:0]          carry,
  output logic [STAGES-1:0]          wrap_pulse,
  output logic                       done,
  output logic                       load_error
);

  // Reject out-of-range geometry at elaboration time.
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("cascade_counter_chain: STAGES must be 1..8");
  end
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("cascade_counter_chain: WIDTH must be 1..16");
  end

  // Count direction. It is tied to up-count when the down option is absent.
  logic count_down;
`ifdef CASCADE_CHAIN_DOWN_EN
  assign count_down = down;
`else
  assign count_down = 1'b0;
`endif

  // The count step is allowed only when no clear or load takes priority.
  logic step_ok;
  assign step_ok = enable & ~clear & ~load;

  logic [STAGES-1:0]       carry_in;
  logic [STAGES-1:0]       at_zero;
  logic [STAGES-1:0]       pass;
  logic [STAGES-1:0]       field_bad;
  logic [STAGES*WIDTH-1:0] next_count;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] max_i;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] field;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] loaded;

    assign max_i = MAX[i*WIDTH +: WIDTH];
    assign cur   = count[i*WIDTH +: WIDTH];
    assign field = load_value[i*WIDTH +: WIDTH];

    assign stage_max[i] = (cur == max_i);
    assign at_zero[i]   = (cur == '0);

    // A stage lets the carry (or borrow) through when it is at its wrap point.
    // A stage with max 0 is always at both ends, so it is transparent.
    assign pass[i] = count_down ? at_zero[i] : stage_max[i];

    if (i == 0) begin : g_first
      assign carry_in[i] = step_ok;
    end else begin : g_rest
      assign carry_in[i] = carry[i-1];
    end

    assign carry[i] = carry_in[i] & pass[i];

    // Out-of-range load fields become 0. This keeps count within max_i.
    assign field_bad[i] = (field > max_i);
    assign loaded       = field_bad[i] ? '0 : field;

    assign stepped = count_down ? (at_zero[i]   ? max_i : cur - 1'b1)
                                : (stage_max[i] ? '0    : cur + 1'b1);

    assign next_count[i*WIDTH +: WIDTH] = clear       ? '0     :
                                          load        ? loaded :
                                          carry_in[i] ? stepped : cur;
  end

`ifdef CASCADE_CHAIN_DOWN_EN
  assign stage_zero = at_zero;
`endif

  assign done = carry[STAGES-1];

  // State register for the stage values, the wrap pulses and the sticky load error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      wrap_pulse <= '0;
      load_error <= 1'b0;
    end else begin
      count      <= next_count;
      wrap_pulse <= carry;
      if (clear) begin
        load_error <= 1'b0;
      end else if (load && (|field_bad)) begin
        load_error <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
